// File: rtl/spec_bin_stream_avg.sv
// spec_bin_stream_avg: per-bin spectrum averager over 2^n_avgs frames with a valid/ready word serialiser.
// Optional macro AVG_ROUND_EN selects round-half-up with saturation instead of truncation.
module spec_bin_stream_avg #(
    parameter int N             = 16,
    parameter int N_OUT         = 8,
    parameter int BINS          = 4,
    parameter int MAX_LOG2_AVGS = 7,
    parameter int SUM_WIDTH     = 32
) (
    input  logic             clk,
    input  logic             arest_n,
    input  logic [7:0]       n_avgs,
    input  logic             in_valid,
    input  logic [N-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_OUT-1:0] out_data,
    output logic             out_last,
    input  logic             clr_status,
    output logic             overrun,
    output logic             frame_err
);
    localparam int WORDS = BINS * N / N_OUT;
    localparam int BUF_W = BINS * N;
    localparam int BIN_W = $clog2(BINS);
    localparam int K_W   = (MAX_LOG2_AVGS > 0) ? $clog2(MAX_LOG2_AVGS + 1) : 1;
    localparam int F_W   = (MAX_LOG2_AVGS > 0) ? MAX_LOG2_AVGS : 1;
    localparam int IDX_W = $clog2(WORDS);

    if (N % N_OUT != 0) begin : g_bad_n_out
        $error("spec_bin_stream_avg: N must be a multiple of N_OUT");
    end
    if (SUM_WIDTH < N + MAX_LOG2_AVGS) begin : g_bad_sum_width
        $error("spec_bin_stream_avg: SUM_WIDTH must be at least N+MAX_LOG2_AVGS");
    end

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SEND = 1'b1} ser_state_t;

    // Divide one accumulated bin by 2^k back to N bits.
    function automatic logic [N-1:0] avg_bin(input logic [SUM_WIDTH-1:0] sum, input logic [K_W-1:0] k);
`ifdef AVG_ROUND_EN
        logic [SUM_WIDTH:0] tmp;
        logic [SUM_WIDTH:0] shifted;
        logic [SUM_WIDTH:0] n_max;
        n_max = {{(SUM_WIDTH + 1 - N){1'b0}}, {N{1'b1}}};
        if (k != {K_W{1'b0}}) begin
            tmp = {1'b0, sum} + ((SUM_WIDTH + 1)'(1) << (k - K_W'(1)));
        end else begin
            tmp = {1'b0, sum};
        end
        shifted = tmp >> k;
        if (shifted > n_max) begin
            avg_bin = {N{1'b1}};
        end else begin
            avg_bin = shifted[N-1:0];
        end
`else
        avg_bin = N'(sum >> k);
`endif
    endfunction

    logic [BIN_W-1:0]     bin_cnt_r;
    logic [F_W-1:0]       frame_cnt_r;
    logic [K_W-1:0]       k_r;
    logic [SUM_WIDTH-1:0] sum_r [BINS];
    logic                 done_r;
    logic [BUF_W-1:0]     buf_r;
    logic [IDX_W-1:0]     idx_r;
    logic                 out_valid_r;
    logic                 out_last_r;
    logic                 overrun_r;
    logic                 frame_err_r;
    ser_state_t           state_r;
    ser_state_t           state_next_s;

    logic                 set_start_s;
    logic [K_W-1:0]       n_clamp_s;
    logic [K_W-1:0]       k_eff_s;
    logic                 bin_is_last_s;
    logic                 frame_is_last_s;
    logic                 sample_err_s;
    logic                 sample_ok_s;
    logic                 set_done_s;
    logic                 hs_s;
    logic                 final_hs_s;
    logic                 load_s;
    logic                 drop_s;
    logic [BUF_W-1:0]     result_s;

    // Frame bookkeeping and handshake decode; k is taken fresh from n_avgs on the first sample of a set.
    always_comb begin
        set_start_s     = (bin_cnt_r == {BIN_W{1'b0}}) && (frame_cnt_r == {F_W{1'b0}});
        n_clamp_s       = (n_avgs > 8'(MAX_LOG2_AVGS)) ? K_W'(MAX_LOG2_AVGS) : K_W'(n_avgs);
        k_eff_s         = set_start_s ? n_clamp_s : k_r;
        bin_is_last_s   = (bin_cnt_r == BIN_W'(BINS - 1));
        frame_is_last_s = ((({1'b0, frame_cnt_r} + (F_W + 1)'(1)) >> k_eff_s) != {(F_W + 1){1'b0}});
        sample_err_s    = in_valid && (in_last != bin_is_last_s);
        sample_ok_s     = in_valid && !sample_err_s;
        set_done_s      = sample_ok_s && bin_is_last_s && frame_is_last_s;
        hs_s            = out_valid_r && out_ready;
        final_hs_s      = hs_s && (idx_r == IDX_W'(WORDS - 1));
        load_s          = done_r && (state_r == ST_IDLE);
        drop_s          = done_r && (state_r == ST_SEND);
    end

    // Averaged spectrum packed with bin 0 in the most significant position.
    always_comb begin
        result_s = {BUF_W{1'b0}};
        for (int b = 0; b < BINS; b++) begin
            result_s[(BINS - b) * N - 1 -: N] = avg_bin(sum_r[b], k_r);
        end
    end

    // Accumulator: first frame of a set loads, later frames add; contents need no reset.
    always_ff @(posedge clk) begin
        if (sample_ok_s) begin
            if (frame_cnt_r == {F_W{1'b0}}) begin
                sum_r[bin_cnt_r] <= SUM_WIDTH'(in_data);
            end else begin
                sum_r[bin_cnt_r] <= sum_r[bin_cnt_r] + SUM_WIDTH'(in_data);
            end
        end
    end

    // Bin/frame counters, latched exponent and set-complete strobe.
    always_ff @(posedge clk or negedge arest_n) begin
        if (!arest_n) begin
            bin_cnt_r   <= {BIN_W{1'b0}};
            frame_cnt_r <= {F_W{1'b0}};
            k_r         <= {K_W{1'b0}};
            done_r      <= 1'b0;
        end else begin
            done_r <= set_done_s;
            if (sample_err_s) begin
                bin_cnt_r   <= {BIN_W{1'b0}};
                frame_cnt_r <= {F_W{1'b0}};
            end else if (sample_ok_s) begin
                if (set_start_s) begin
                    k_r <= n_clamp_s;
                end
                if (bin_is_last_s) begin
                    bin_cnt_r   <= {BIN_W{1'b0}};
                    frame_cnt_r <= frame_is_last_s ? {F_W{1'b0}} : frame_cnt_r + F_W'(1);
                end else begin
                    bin_cnt_r <= bin_cnt_r + BIN_W'(1);
                end
            end
        end
    end

    // Serialiser next-state.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: state_next_s = load_s ? ST_SEND : ST_IDLE;
            ST_SEND: state_next_s = final_hs_s ? ST_IDLE : ST_SEND;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Serialiser state register.
    always_ff @(posedge clk or negedge arest_n) begin
        if (!arest_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Output buffer shifts one slice up per accepted word, so the top slice is always the current word.
    always_ff @(posedge clk or negedge arest_n) begin
        if (!arest_n) begin
            buf_r       <= {BUF_W{1'b0}};
            idx_r       <= {IDX_W{1'b0}};
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else if (load_s) begin
            buf_r       <= result_s;
            idx_r       <= {IDX_W{1'b0}};
            out_valid_r <= 1'b1;
            out_last_r  <= 1'b0;
        end else if (final_hs_s) begin
            idx_r       <= {IDX_W{1'b0}};
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else if (hs_s) begin
            buf_r      <= buf_r << N_OUT;
            idx_r      <= idx_r + IDX_W'(1);
            out_last_r <= (idx_r == IDX_W'(WORDS - 2));
        end
    end

    // Sticky status flags; a new event beats a simultaneous clear.
    always_ff @(posedge clk or negedge arest_n) begin
        if (!arest_n) begin
            overrun_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            overrun_r   <= drop_s ? 1'b1 : (clr_status ? 1'b0 : overrun_r);
            frame_err_r <= sample_err_s ? 1'b1 : (clr_status ? 1'b0 : frame_err_r);
        end
    end

    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign out_data  = buf_r[BUF_W-1 -: N_OUT];
    assign overrun   = overrun_r;
    assign frame_err = frame_err_r;
endmodule

// File: tb/tb_spec_bin_stream_avg.sv
// Directed bench for spec_bin_stream_avg: expected words are queued as frames are driven and
// popped by a monitor on every output handshake.
`timescale 1ns/1ps
module tb_spec_bin_stream_avg;
    localparam int N = 16;
    localparam int N_OUT = 8;
    localparam int BINS = 4;

    logic        clk = 1'b0;
    logic        arest_n = 1'b0;
    logic [7:0]  n_avgs = 8'd0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'd0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
    logic        out_last;
    logic        clr_status = 1'b0;
    logic        overrun;
    logic        frame_err;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    int hs0 = 0;
    int ready_mode = 0;
    int rdy_cnt = 0;
    logic [8:0] exp_q[$];
    logic [8:0] exp_w;
    longint unsigned acc[BINS];
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = 8'd0;
    logic prev_last = 1'b0;

    spec_bin_stream_avg #(.N(N), .N_OUT(N_OUT), .BINS(BINS), .MAX_LOG2_AVGS(7), .SUM_WIDTH(32)) dut (
        .clk(clk), .arest_n(arest_n), .n_avgs(n_avgs),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .clr_status(clr_status), .overrun(overrun), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] exp_avg(input longint unsigned s, input int k);
        longint unsigned v;
`ifdef AVG_ROUND_EN
        v = (s + ((k > 0) ? (64'd1 << (k - 1)) : 64'd0)) >> k;
        if (v > 64'hFFFF) v = 64'hFFFF;
`else
        v = s >> k;
`endif
        return v[15:0];
    endfunction

    // Scoreboard monitor: pops one expected word per handshake and checks stalled words hold.
    always @(negedge clk) begin
        if (arest_n) begin
            if (prev_stall) begin
                checks++;
                assert ({out_valid, out_last, out_data} === {1'b1, prev_last, prev_data}) else begin
                    errors++;
                    $error("FAIL stall_hold got=%h exp=%h", {out_valid, out_last, out_data}, {1'b1, prev_last, prev_data});
                end
            end
            if (out_valid && out_ready) begin
                hs_cnt++;
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_word got=%h exp=none", {out_last, out_data});
                end
                if (exp_q.size() != 0) begin
                    exp_w = exp_q.pop_front();
                    checks++;
                    assert ({out_last, out_data} === exp_w) else begin
                        errors++;
                        $error("FAIL word got=%h exp=%h", {out_last, out_data}, exp_w);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        rdy_cnt++;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = (rdy_cnt % 3 == 0);
            default: out_ready = 1'b0;
        endcase
    endtask

    task automatic send_sample(input logic [15:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 16'd0;
    endtask

    task automatic send_frame(input logic [15:0] v0, input logic [15:0] v1, input logic [15:0] v2, input logic [15:0] v3);
        logic [15:0] v[BINS];
        v = '{v0, v1, v2, v3};
        for (int b = 0; b < BINS; b++) begin
            send_sample(v[b], b == BINS - 1);
            acc[b] += v[b];
        end
    endtask

    task automatic clear_acc();
        for (int b = 0; b < BINS; b++) acc[b] = 0;
    endtask

    task automatic push_spectrum(input int k);
        logic [15:0] v;
        for (int b = 0; b < BINS; b++) begin
            v = exp_avg(acc[b], k);
            exp_q.push_back({1'b0, v[15:8]});
            exp_q.push_back({(b == BINS - 1), v[7:0]});
        end
        clear_acc();
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && !(exp_q.size() == 0 && !out_valid); i++) tick();
        check("drain", {30'd0, (exp_q.size() == 0), !out_valid}, 32'd3);
    endtask

    initial begin
        clear_acc();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", {20'd0, out_valid, out_last, overrun, frame_err, out_data}, 32'd0);
        arest_n = 1'b1;
        tick();

        // basic average, n_avgs=2
        n_avgs = 8'd2;
        for (int f = 0; f < 4; f++) send_frame(16'(f), 16'(100 + f), 16'(200 + f), 16'(300 + f));
        push_spectrum(2);
        check("valid_t1", {31'd0, out_valid}, 32'd0);
        tick();
        check("valid_t2", {31'd0, out_valid}, 32'd1);
        drain();

        // back-pressure
        hs0 = hs_cnt;
        ready_mode = 1;
        for (int f = 0; f < 4; f++) send_frame(16'(f), 16'(100 + f), 16'(200 + f), 16'(300 + f));
        push_spectrum(2);
        drain();
        ready_mode = 0;
        check("bp_handshakes", 32'(hs_cnt - hs0), 32'd8);

        // overrun: second pass-through spectrum dropped while first is stalled
        ready_mode = 2;
        n_avgs = 8'd0;
        tick();
        send_frame(16'd11, 16'd22, 16'd33, 16'd44);
        push_spectrum(0);
        send_frame(16'd55, 16'd66, 16'd77, 16'd88);
        clear_acc();
        tick();
        check("overrun_set", {31'd0, overrun}, 32'd1);
        ready_mode = 0;
        drain();
        check("overrun_sticky", {31'd0, overrun}, 32'd1);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        check("overrun_clr", {31'd0, overrun}, 32'd0);

        // frame error: in_last on bin 2
        n_avgs = 8'd2;
        send_sample(16'd5, 1'b0);
        send_sample(16'd6, 1'b0);
        send_sample(16'd7, 1'b1);
        check("frame_err_set", {31'd0, frame_err}, 32'd1);
        for (int f = 0; f < 4; f++) send_frame(16'(f * 7 + 1), 16'(f * 13 + 1000), 16'(40000 + f), 16'(65535 - f));
        push_spectrum(2);
        drain();
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        check("frame_err_clr", {31'd0, frame_err}, 32'd0);
        // missing in_last on bin 3 together with clr_status: error wins
        send_sample(16'd1, 1'b0);
        send_sample(16'd1, 1'b0);
        send_sample(16'd1, 1'b0);
        clr_status = 1'b1;
        send_sample(16'd1, 1'b0);
        clr_status = 1'b0;
        check("err_beats_clr", {31'd0, frame_err}, 32'd1);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        check("frame_err_clr2", {31'd0, frame_err}, 32'd0);

        // clamp 9 -> 7 over 128 frames; mid-set change to 0 must not take effect
        n_avgs = 8'd9;
        send_frame(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        n_avgs = 8'd0;
        for (int f = 1; f < 128; f++) send_frame(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        push_spectrum(7);
        drain();
        // new set picks up k=0
        send_frame(16'h1234, 16'hABCD, 16'h0F0F, 16'h8001);
        push_spectrum(0);
        drain();

        // reset during SEND
        ready_mode = 2;
        tick();
        send_frame(16'd1, 16'd2, 16'd3, 16'd4);
        tick();
        tick();
        check("send_active", {31'd0, out_valid}, 32'd1);
        #2;
        arest_n = 1'b0;
        #1;
        check("rst_async", {20'd0, out_valid, out_last, overrun, frame_err, out_data}, 32'd0);
        exp_q.delete();
        clear_acc();
        tick();
        arest_n = 1'b1;
        ready_mode = 0;
        n_avgs = 8'd1;
        send_frame(16'd9, 16'd8, 16'd7, 16'd6);
        repeat (5) tick();
        check("no_early_out", {31'd0, out_valid}, 32'd0);
        send_frame(16'd1, 16'd1, 16'd1, 16'd1);
        push_spectrum(1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
